// File: rtl/wb_stage_if.sv
// Writeback stage bus: ALU bundle handshake plus data-memory write port.
// The stage itself takes the slave view; its environment takes the master view.
interface wb_stage_if #(
  parameter int WORD_W = 32
);
  logic              alu_valid;
  logic              alu_ready;
  logic [WORD_W-1:0] result;
  logic [WORD_W-1:0] nxtpc;
  logic [WORD_W-1:0] dest_addr;
  logic              wr_en;
  logic              halt_in;
  logic              mem_req;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (
    output alu_valid,
    output result,
    output nxtpc,
    output dest_addr,
    output wr_en,
    output halt_in,
    output mem_ack,
    input  alu_ready,
    input  mem_req,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  alu_valid,
    input  result,
    input  nxtpc,
    input  dest_addr,
    input  wr_en,
    input  halt_in,
    input  mem_ack,
    output alu_ready,
    output mem_req,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: commits ALU bundles, issuing an optional memory write
// that must be acknowledged within TIMEOUT cycles or the stage faults.
module wb_stage #(
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_if.slave         bus,
  output logic [WORD_W-1:0] pc,
  output logic              commit,
  output logic [15:0]       retired,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_HALT
  } state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WORD_W-1:0] pc_d;
  logic [WORD_W-1:0] npc_q;
  logic [WORD_W-1:0] npc_d;
  logic              req_q;
  logic              req_d;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] addr_d;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] wdata_d;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic              commit_d;
  logic [15:0]       ret_d;
  logic              fault_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc      <= '0;
      npc_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      commit  <= 1'b0;
      retired <= '0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
      npc_q   <= npc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      commit  <= commit_d;
      retired <= ret_d;
      fault   <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    npc_d    = npc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    commit_d = 1'b0;
    ret_d    = retired;
    fault_d  = fault;
    unique case (state_q)
      S_IDLE: begin
        if (bus.alu_valid) begin
          // halt outranks a write request in the same bundle
          if (bus.halt_in) begin
            commit_d = 1'b1;
            ret_d    = retired + 16'd1;
            state_d  = S_HALT;
          end else if (bus.wr_en) begin
            addr_d  = bus.dest_addr;
            wdata_d = bus.result;
            npc_d   = bus.nxtpc;
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            pc_d     = bus.nxtpc;
            commit_d = 1'b1;
            ret_d    = retired + 16'd1;
          end
        end
      end
      S_WRITE: begin
        // ack beats the timeout when both land on the same edge
        if (bus.mem_ack) begin
          req_d    = 1'b0;
          pc_d     = npc_q;
          commit_d = 1'b1;
          ret_d    = retired + 16'd1;
          state_d  = S_IDLE;
        end else if (cnt_q == LIMIT) begin
          cnt_d   = cnt_q + 8'd1;
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_HALT: begin
        req_d = 1'b0;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.alu_ready = (state_q == S_IDLE);
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: per-scenario tasks plus a commit
// scoreboard holding the expected pc/retired of every retirement.
module tb_wb_stage;
  localparam int W  = 32;
  localparam int TO = 4;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [15:0]  ret;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pc;
  logic         commit;
  logic [15:0]  retired;
  logic         halted;
  logic         fault;

  int           n_cmp = 0;
  int           n_bad = 0;
  exp_t         sb[$];
  logic [W-1:0] exp_pc = '0;
  logic [15:0]  exp_ret = '0;

  wb_stage_if #(.WORD_W(W)) bus ();

  wb_stage #(
    .WORD_W(W),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .pc(pc),
    .commit(commit),
    .retired(retired),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && commit) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected_commit got pc=%h ret=%0d want no commit",
                 pc, retired);
      end else begin
        e = sb.pop_front();
        if (pc !== e.pc || retired !== e.ret) begin
          n_bad++;
          $display("FAIL sb_commit got pc=%h ret=%0d want pc=%h ret=%0d",
                   pc, retired, e.pc, e.ret);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.result    = '0;
    bus.nxtpc     = '0;
    bus.dest_addr = '0;
    bus.wr_en     = 1'b0;
    bus.halt_in   = 1'b0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    exp_pc  = '0;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc  = exp_pc;
    e.ret = exp_ret;
    sb.push_back(e);
  endtask

  task automatic straight(input logic [W-1:0] npc);
    bus.alu_valid = 1'b1;
    bus.wr_en     = 1'b0;
    bus.halt_in   = 1'b0;
    bus.nxtpc     = npc;
    exp_pc  = npc;
    exp_ret = exp_ret + 16'd1;
    push_exp();
    tick();
  endtask

  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] npc);
    bus.alu_valid = 1'b1;
    bus.wr_en     = 1'b1;
    bus.halt_in   = 1'b0;
    bus.dest_addr = a;
    bus.result    = d;
    bus.nxtpc     = npc;
    bus.mem_ack   = 1'b0;
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== a ||
        bus.mem_wdata !== d || bus.alu_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_issue got req=%b a=%h d=%h rdy=%b want 1 %h %h 0",
               bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.alu_ready, a, d);
    end
    // junk bundle held valid while busy must be ignored
    bus.wr_en = 1'b0;
    bus.nxtpc = 32'hdead_beef;
  endtask

  task automatic test_reset();
    bus.alu_valid = 1'b1;
    bus.nxtpc     = 32'h1111;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pc !== '0 || retired !== '0 || commit !== 1'b0 ||
        halted !== 1'b0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got pc=%h ret=%0d c=%b h=%b f=%b want zeros",
               pc, retired, commit, halted, fault);
    end
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_bus got req=%b a=%h d=%h rdy=%b want 0 0 0 1",
               bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.alu_ready);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    bus.mem_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      straight(W'(i));
      n_cmp++;
      if (pc !== W'(i) || commit !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_%0d got pc=%h commit=%b want %h 1",
                 i, pc, commit, i);
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (commit !== 1'b0 || retired !== 16'd3 ||
        bus.mem_req !== 1'b0 || bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_end got c=%b ret=%0d req=%b rdy=%b want 0 3 0 1",
               commit, retired, bus.mem_req, bus.alu_ready);
    end
  endtask

  task automatic test_write();
    do_write(32'h40, 32'h1234, 32'd5);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 ||
          bus.mem_wdata !== 32'h1234 || bus.alu_ready !== 1'b0 ||
          commit !== 1'b0 || pc !== exp_pc) begin
        n_bad++;
        $display("FAIL wr_hold_%0d got req=%b a=%h d=%h rdy=%b c=%b pc=%h",
                 k, bus.mem_req, bus.mem_addr, bus.mem_wdata,
                 bus.alu_ready, commit, pc);
      end
    end
    bus.alu_valid = 1'b0;
    bus.mem_ack   = 1'b1;
    exp_pc  = 32'd5;
    exp_ret = exp_ret + 16'd1;
    push_exp();
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || pc !== 32'd5 || commit !== 1'b1 ||
        bus.alu_ready !== 1'b1 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_ack got req=%b pc=%h c=%b rdy=%b f=%b want 0 5 1 1 0",
               bus.mem_req, pc, commit, bus.alu_ready, fault);
    end
    tick();
    n_cmp++;
    if (commit !== 1'b0 || retired !== exp_ret) begin
      n_bad++;
      $display("FAIL wr_single_commit got c=%b ret=%0d want 0 %0d",
               commit, retired, exp_ret);
    end
  endtask

  task automatic test_ack_at_limit();
    do_write(32'h80, 32'ha5a5, 32'h99);
    bus.alu_valid = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin
        n_bad++;
        $display("FAIL lim_wait_%0d got req=%b f=%b want 1 0",
                 k, bus.mem_req, fault);
      end
    end
    bus.mem_ack = 1'b1;
    exp_pc  = 32'h99;
    exp_ret = exp_ret + 16'd1;
    push_exp();
    tick();
    bus.mem_ack = 1'b0;
    n_cmp++;
    if (pc !== 32'h99 || commit !== 1'b1 || fault !== 1'b0 ||
        halted !== 1'b0 || bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lim_ack got pc=%h c=%b f=%b h=%b rdy=%b want 99 1 0 0 1",
               pc, commit, fault, halted, bus.alu_ready);
    end
  endtask

  task automatic test_timeout();
    do_write(32'hc0, 32'h5555, 32'h1000);
    bus.alu_valid = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      tick();
      n_cmp++;
      if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin
        n_bad++;
        $display("FAIL to_wait_%0d got req=%b f=%b want 1 0",
                 k, bus.mem_req, fault);
      end
    end
    tick();
    n_cmp++;
    if (bus.mem_req !== 1'b0 || fault !== 1'b1 || halted !== 1'b1 ||
        pc !== exp_pc || retired !== exp_ret || bus.alu_ready !== 1'b0 ||
        commit !== 1'b0) begin
      n_bad++;
      $display("FAIL to_fault got req=%b f=%b h=%b pc=%h ret=%0d rdy=%b c=%b",
               bus.mem_req, fault, halted, pc, retired, bus.alu_ready, commit);
    end
    bus.alu_valid = 1'b1;
    bus.nxtpc     = 32'h4444;
    bus.mem_ack   = 1'b1;
    repeat (2) tick();
    idle_inputs();
    n_cmp++;
    if (pc !== exp_pc || fault !== 1'b1 || bus.alu_ready !== 1'b0 ||
        bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL to_stuck got pc=%h f=%b rdy=%b req=%b",
               pc, fault, bus.alu_ready, bus.mem_req);
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.halt_in   = 1'b1;
    bus.wr_en     = 1'b1;
    bus.nxtpc     = 32'h77;
    exp_ret = exp_ret + 16'd1;
    push_exp();
    tick();
    n_cmp++;
    if (commit !== 1'b1 || bus.mem_req !== 1'b0 || halted !== 1'b1 ||
        pc !== '0 || bus.alu_ready !== 1'b0 || retired !== 16'd1) begin
      n_bad++;
      $display("FAIL halt_enter got c=%b req=%b h=%b pc=%h rdy=%b ret=%0d",
               commit, bus.mem_req, halted, pc, bus.alu_ready, retired);
    end
    bus.halt_in = 1'b0;
    bus.wr_en   = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (commit !== 1'b0 || pc !== '0 || retired !== 16'd1 ||
        bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL halt_ignore got c=%b pc=%h ret=%0d req=%b want 0 0 1 0",
               commit, pc, retired, bus.mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (halted !== 1'b0 || retired !== '0 || pc !== '0 ||
        fault !== 1'b0 || bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_async_rst got h=%b ret=%0d pc=%h f=%b rdy=%b",
               halted, retired, pc, fault, bus.alu_ready);
    end
    do_reset();
  endtask

  task automatic test_reset_in_write();
    do_write(32'h10, 32'h22, 32'h33);
    bus.alu_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0 ||
        bus.mem_wdata !== '0 || pc !== '0 || bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rstw_drop got req=%b a=%h d=%h pc=%h rdy=%b",
               bus.mem_req, bus.mem_addr, bus.mem_wdata, pc, bus.alu_ready);
    end
    do_reset();
    bus.mem_ack = 1'b1;
    repeat (2) tick();
    bus.mem_ack = 1'b0;
    n_cmp++;
    if (pc !== '0 || retired !== '0 || bus.mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL rstw_discard got pc=%h ret=%0d req=%b want 0 0 0",
               pc, retired, bus.mem_req);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    straight(32'hffff_ffff);
    n_cmp++;
    if (pc !== 32'hffff_ffff) begin
      n_bad++;
      $display("FAIL wrap_pc_max got %h want ffffffff", pc);
    end
    straight(32'h0);
    n_cmp++;
    if (pc !== 32'h0) begin
      n_bad++;
      $display("FAIL wrap_pc_zero got %h want 0", pc);
    end
    for (int i = 2; i < 65536; i++) straight(W'(i));
    idle_inputs();
    tick();
    n_cmp++;
    if (retired !== 16'h0 || pc !== 32'hffff || sb.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_retired got ret=%h pc=%h pend=%0d want 0 ffff 0",
               retired, pc, sb.size());
    end
  endtask

  initial begin
    idle_inputs();
    #2;
    test_reset();
    test_back_to_back();
    test_write();
    test_ack_at_limit();
    test_timeout();
    test_halt();
    test_reset_in_write();
    test_wrap();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter WORD_W, default 32, width of result, PC, address and data paths, equal to the `word_l width.
REQ-002 Parameter TIMEOUT, default 15, maximum WRITE cycles without mem_ack before fault; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid  input  1  ALU output bundle valid this cycle.
REQ-006 alu_ready  output  1  stage accepts a bundle this cycle.
REQ-007 result  input  WORD_W  ALU result to commit.
REQ-008 nxtpc  input  WORD_W  next PC computed by the ALU.
REQ-009 dest_addr  input  WORD_W  data-memory write address for result.
REQ-010 wr_en  input  1  bundle writes result to memory.
REQ-011 halt_in  input  1  bundle is a halt instruction.
REQ-012 pc  output  WORD_W  committed program counter, registered.
REQ-013 mem_req, mem_addr, mem_wdata  output  1/WORD_W/WORD_W  memory write request, address and data, registered.
REQ-014 mem_ack  input  1  memory accepted the write this cycle.
REQ-015 commit  output  1  one-cycle pulse per retired instruction.
REQ-016 retired  output  16  count of retired instructions.
REQ-017 halted, fault  output  1  stage halted; sticky memory-timeout flag.

Function
REQ-018 States: IDLE, WRITE, HALT; encoding is free.
REQ-019 alu_ready SHALL be 1 exactly in IDLE, combinationally from state only.
REQ-020 Transfer occurs on a rising edge with alu_valid=1 and alu_ready=1; bundle inputs are ignored otherwise.
REQ-021 IDLE transfer, halt_in=1: pc unchanged, no write (wr_en ignored), commit pulses next cycle, retired increments, state -> HALT.
REQ-022 IDLE transfer, halt_in=0, wr_en=0: pc <= nxtpc, commit=1 for the next cycle, retired increments, stay IDLE.
REQ-023 IDLE transfer, halt_in=0, wr_en=1: mem_addr <= dest_addr, mem_wdata <= result, nxtpc captured internally, mem_req <= 1, wait counter <= 0, state -> WRITE.
REQ-024 WRITE: mem_req, mem_addr, mem_wdata stable until the edge mem_ack=1 is sampled.
REQ-025 WRITE with mem_ack=1 at an edge: mem_req <= 0, pc <= captured nxtpc, commit=1 for the next cycle, retired increments, state -> IDLE; the next bundle is acceptable the cycle after.
REQ-026 WRITE with mem_ack=0: wait counter increments; when it reaches TIMEOUT at an edge: mem_req <= 0, fault <= 1, pc unchanged, no commit, state -> HALT.
REQ-027 mem_ack=1 and the timeout limit at the same edge: ack wins, normal commit per REQ-025.
REQ-028 mem_ack outside WRITE SHALL be ignored.
REQ-029 HALT: halted=1, alu_ready=0, mem_req=0; exited only by reset.
REQ-030 pc wraps modulo 2^WORD_W; retired wraps from 0xFFFF to 0x0000.
REQ-031 commit SHALL never be high two consecutive cycles from the write path; straight-line (wr_en=0) bundles may commit back-to-back.

Reset
REQ-032 rst_n=0 SHALL immediately force: state IDLE, pc=0, mem_req=0, mem_addr=0, mem_wdata=0, commit=0, retired=0, halted=0, fault=0, wait counter=0.
REQ-033 Reset asserted during WRITE SHALL drop mem_req without waiting for a clock edge and discard the pending write and PC update.
REQ-034 First transfer is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Three back-to-back bundles wr_en=0, nxtpc=1,2,3 -> pc=1,2,3 on consecutive cycles, commit high 3 cycles, retired=3.
REQ-036 Bundle wr_en=1, dest_addr=0x40, result=0x1234, nxtpc=5; mem_ack after 3 cycles -> mem_req high 3 cycles with addr 0x40/data 0x1234, pc=5 after ack, one commit pulse, alu_ready low throughout.
REQ-037 TIMEOUT=4, write with mem_ack never asserted -> after 4 WRITE cycles mem_req=0, fault=1, halted=1, pc unchanged, retired unchanged, alu_ready stays 0.
REQ-038 mem_ack and timeout limit on the same edge -> commit, pc updated, fault=0, state IDLE.
REQ-039 halt_in=1 with wr_en=1 -> no mem_req, one commit pulse, halted=1; later alu_valid ignored; rst_n low mid-cycle clears all outputs immediately.
REQ-040 pc=0xFFFFFFFF then bundle nxtpc=0 -> pc=0; 65536 straight-line commits -> retired returns to 0.
